// File: rtl/adf4351_pkg.sv
// Shared types and register field positions for the ADF4351 tune controller.
package adf4351_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_LOCK_WAIT
  } state_e;

  // Serialiser phases: data bits, post-bit clock-low tail, LE pulse, inter-word gap
  typedef enum logic [2:0] {
    SP_IDLE,
    SP_BITS,
    SP_TAIL,
    SP_LE,
    SP_GAP
  } spi_phase_e;

  // Register index carried in bits [2:0] of every word
  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;

  // Field positions
  localparam int INT_LSB   = 15;  // R0 INT
  localparam int FRAC_LSB  = 3;   // R0 FRAC
  localparam int PHASE_LSB = 15;  // R1 phase value
  localparam int MOD_LSB   = 3;   // R1 MOD
  localparam int DIV_LSB   = 20;  // R4 RF divider select

  typedef struct packed {
    logic [15:0] int_v;
    logic [11:0] frac;
    logic [11:0] mod;
    logic [2:0]  rfdiv;
  } tune_t;

  // Fractional-N constraints the part can actually realise
  function automatic logic tune_valid(tune_t t);
    return (t.mod >= 12'd2) && (t.frac < t.mod) &&
           (t.int_v >= 16'd23) && (t.rfdiv <= 3'd6);
  endfunction

endpackage

// File: rtl/adf4351_spi_shift.sv
// 32-bit word serialiser for the ADF4351 3-wire bus.
// MSB first; data changes with the falling clock edge; each half-period is
// CLK_DIV cycles. After bit 0: clock low tail, LE pulse, then a quiet gap,
// all CLK_DIV cycles each. done pulses in the last gap cycle.
module adf4351_spi_shift
  import adf4351_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] word,
  output logic        sclk,
  output logic        sdata,
  output logic        le,
  output logic        latching,
  output logic        done
);

  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_DIV - 1);

  spi_phase_e      phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [31:0]     shreg_q, shreg_d;
  logic            sclk_q, sclk_d;
  logic            le_q, le_d;

  // Phase sequencing; the shift register drains to zero so data idles low
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    le_d    = le_q;
    done    = 1'b0;
    case (phase_q)
      SP_IDLE: begin
        if (start) begin
          phase_d = SP_BITS;
          shreg_d = word;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = 5'd31;
        end
      end
      SP_BITS: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[30:0], 1'b0};
          if (bit_q == 5'd0) phase_d = SP_TAIL;
          else               bit_d   = bit_q - 5'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HALF_LAST) sclk_d = 1'b1;
        end
      end
      SP_TAIL: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          le_d    = 1'b1;
          phase_d = SP_LE;
        end else cnt_d = cnt_q + 1'b1;
      end
      SP_LE: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          le_d    = 1'b0;
          phase_d = SP_GAP;
        end else cnt_d = cnt_q + 1'b1;
      end
      SP_GAP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          phase_d = SP_IDLE;
          done    = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: phase_d = SP_IDLE;
    endcase
  end

  // Serialiser state registers
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= SP_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      le_q    <= le_d;
    end
  end

  assign sclk     = sclk_q;
  assign sdata    = shreg_q[31];
  assign le       = le_q;
  assign latching = (phase_q == SP_TAIL) || (phase_q == SP_LE) || (phase_q == SP_GAP);

endmodule

// File: rtl/adf4351_tune_ctrl.sv
// ADF4351 tune sequencer: power-up delay, register image build, R5..R0 write,
// lock qualification and loss-of-lock detection.
// Optional: define ADF4351_FAST_RETUNE_EN to write only R1,R0 when MOD and the
// RF divider match the values already in the part.
module adf4351_tune_ctrl
  import adf4351_pkg::*;
#(
  parameter int          CLK_DIV   = 8,
  parameter int          PWRUP_CYC = 50000,
  parameter int          LOCK_HOLD = 64,
  parameter int          LOCK_TMO  = 500000,
  parameter logic [31:0] R2_CFG    = 32'h0000_4E42,
  parameter logic [31:0] R3_CFG    = 32'h0000_04B3,
  parameter logic [31:0] R4_CFG    = 32'h00EC_803C,
  parameter logic [31:0] R5_CFG    = 32'h0058_0005,
  parameter logic [15:0] DEF_INT   = 16'd64,
  parameter logic [11:0] DEF_FRAC  = 12'd0,
  parameter logic [11:0] DEF_MOD   = 12'd2,
  parameter logic [2:0]  DEF_RFDIV = 3'd0
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        tune_req,
  input  logic [15:0] tune_int,
  input  logic [11:0] tune_frac,
  input  logic [11:0] tune_mod,
  input  logic [2:0]  tune_rfdiv,
  output logic        ready,
  output logic        tune_err,
  output logic        locked,
  output logic        lock_err,
  output logic        vco_clk,
  output logic        vco_data,
  output logic        vco_le,
  output logic        vco_ce,
  input  logic        vco_ld
);

  localparam int PW = $clog2(PWRUP_CYC) + 1;
  localparam int HW = $clog2(LOCK_HOLD) + 1;
  localparam int TW = $clog2(LOCK_TMO) + 1;
  localparam logic [PW-1:0] PWR_LAST  = PW'(PWRUP_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_HOLD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TMO - 1);

  state_e        state_q, state_d;
  logic [2:0]    reg_idx_q, reg_idx_d;
  tune_t         tune_q, tune_d, req;
  logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [HW-1:0] loss_cnt_q, loss_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          ce_q, ce_d;
  logic          ready_q, ready_d;
  logic          tune_err_q, tune_err_d;
  logic          locked_q, locked_d;
  logic          lock_err_q, lock_err_d;
  logic          ld_s1_q, ld_s1_d;
  logic          ld_s2_q, ld_s2_d;
  logic          ld_sync;
  logic [2:0]    first_idx;
  logic          spi_start, spi_latching, spi_done;
  logic [31:0]   spi_word;

  assign req     = {tune_int, tune_frac, tune_mod, tune_rfdiv};
  assign ld_sync = ld_s2_q;

`ifdef ADF4351_FAST_RETUNE_EN
  // In IDLE tune_q always holds what the part was last programmed with
  assign first_idx = ((req.mod == tune_q.mod) && (req.rfdiv == tune_q.rfdiv)) ? REG_R1 : REG_R5;
`else
  assign first_idx = REG_R5;
`endif

  // Register image for the word currently selected
  always_comb begin
    spi_word = '0;
    case (reg_idx_q)
      REG_R0: spi_word = (32'(tune_q.int_v) << INT_LSB) | (32'(tune_q.frac) << FRAC_LSB) | 32'(REG_R0);
      REG_R1: spi_word = (32'd1 << PHASE_LSB) | (32'(tune_q.mod) << MOD_LSB) | 32'(REG_R1);
      REG_R2: spi_word = {R2_CFG[31:3], REG_R2};
      REG_R3: spi_word = {R3_CFG[31:3], REG_R3};
      REG_R4: spi_word = (R4_CFG & ~(32'h7 << DIV_LSB) & ~32'h7) |
                         (32'(tune_q.rfdiv) << DIV_LSB) | 32'(REG_R4);
      REG_R5: spi_word = {R5_CFG[31:3], REG_R5};
      default: spi_word = '0;
    endcase
  end

  // Next-state, counters and status outputs
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    tune_d     = tune_q;
    pwr_cnt_d  = pwr_cnt_q;
    hold_cnt_d = '0;
    loss_cnt_d = '0;
    tmo_cnt_d  = '0;
    ce_d       = 1'b1;
    tune_err_d = 1'b0;
    locked_d   = locked_q;
    lock_err_d = lock_err_q;
    ld_s1_d    = vco_ld;
    ld_s2_d    = ld_s1_q;
    spi_start  = 1'b0;
    case (state_q)
      ST_PWRUP: begin
        if (ce_q) begin
          if (pwr_cnt_q == PWR_LAST) begin
            state_d   = ST_LOAD;
            reg_idx_d = REG_R5;
            tune_d    = '{int_v: DEF_INT, frac: DEF_FRAC, mod: DEF_MOD, rfdiv: DEF_RFDIV};
          end else pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // Loss of lock while parked: drop locked, no automatic retune
        if (locked_q && !ld_sync) begin
          if (loss_cnt_q == HOLD_LAST) locked_d = 1'b0;
          else                         loss_cnt_d = loss_cnt_q + 1'b1;
        end
        if (tune_req) begin
          if (tune_valid(req)) begin
            tune_d     = req;
            locked_d   = 1'b0;
            lock_err_d = 1'b0;
            reg_idx_d  = first_idx;
            state_d    = ST_LOAD;
          end else tune_err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        spi_start = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (spi_latching) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (spi_done) begin
          if (reg_idx_q == REG_R0) state_d = ST_LOCK_WAIT;
          else begin
            reg_idx_d = reg_idx_q - 3'd1;
            state_d   = ST_LOAD;
          end
        end
      end
      ST_LOCK_WAIT: begin
        // Lock qualification wins over a timeout in the same cycle
        if (ld_sync && (hold_cnt_q == HOLD_LAST)) begin
          locked_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          lock_err_d = 1'b1;
          locked_d   = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (ld_sync) hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Sequencer state and status registers
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PWRUP;
      reg_idx_q  <= REG_R5;
      tune_q     <= '0;
      pwr_cnt_q  <= '0;
      hold_cnt_q <= '0;
      loss_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      ce_q       <= 1'b0;
      ready_q    <= 1'b0;
      tune_err_q <= 1'b0;
      locked_q   <= 1'b0;
      lock_err_q <= 1'b0;
      ld_s1_q    <= 1'b0;
      ld_s2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      tune_q     <= tune_d;
      pwr_cnt_q  <= pwr_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ce_q       <= ce_d;
      ready_q    <= ready_d;
      tune_err_q <= tune_err_d;
      locked_q   <= locked_d;
      lock_err_q <= lock_err_d;
      ld_s1_q    <= ld_s1_d;
      ld_s2_q    <= ld_s2_d;
    end
  end

  adf4351_spi_shift #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .start    (spi_start),
    .word     (spi_word),
    .sclk     (vco_clk),
    .sdata    (vco_data),
    .le       (vco_le),
    .latching (spi_latching),
    .done     (spi_done)
  );

  assign vco_ce   = ce_q;
  assign ready    = ready_q;
  assign tune_err = tune_err_q;
  assign locked   = locked_q;
  assign lock_err = lock_err_q;

endmodule
